vect_argmax: RTL and testbench

Downstream stage of the matrix-vector multiplier. Once the multiplier has finished, it scans the y result BRAM, which holds length_M IEEE-754 fp32 logits. It reports the index and value of the largest element to the PS. The PS starts and acknowledges a scan through AXI4-Lite control/status words, using the same start/done/ack handshake as the multiplier.

---
 rtl/vect_argmax_pkg.sv | 19 +
 rtl/vect_argmax_if.sv | 28 ++
 rtl/fp32_gt.sv | 26 ++
 rtl/vect_argmax.sv | 123 ++++++++++++
 tb/tb_vect_argmax.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vect_argmax_pkg.sv
// Shared types and helpers for the fp32 argmax scanner.
package vect_argmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0]  FP_EXP_ALL1    = 8'hFF;
    localparam int unsigned BYTES_PER_WORD = 4;

    // All-ones exponent with a non-zero mantissa; the sign bit is irrelevant.
    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == FP_EXP_ALL1) && (f[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/vect_argmax_if.sv
// PS control/status and y-BRAM port bundle for vect_argmax.
interface vect_argmax_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [31:0]       ps_control;
    logic [31:0]       pl_status;
    logic [ADDR_W-1:0] bram_addr_y;
    logic [31:0]       bram_rddata_y;
    logic [31:0]       bram_wrdata_y;
    logic [3:0]        bram_we_y;
    logic [15:0]       max_index;
    logic [31:0]       max_value;
    logic              max_valid;
    logic [31:0]       state;

    // The argmax block is the slave of the PS handshake and the reader of the BRAM.
    modport slave (
        input  ps_control, bram_rddata_y,
        output pl_status, bram_addr_y, bram_wrdata_y, bram_we_y,
               max_index, max_value, max_valid, state
    );

    modport master (
        output ps_control, bram_rddata_y,
        input  pl_status, bram_addr_y, bram_wrdata_y, bram_we_y,
               max_index, max_value, max_valid, state
    );
endinterface

// File: rtl/fp32_gt.sv
// Strict greater-than on two non-NaN fp32 bit patterns (+0 == -0).
module fp32_gt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b
);
    logic a_zero;
    logic b_zero;

    assign a_zero = (a[30:0] == 31'd0);
    assign b_zero = (b[30:0] == 31'd0);

    // Sign-magnitude ordering: magnitudes order inversely when both are negative.
    always_comb begin
        a_gt_b = 1'b0;
        if (a_zero && b_zero) begin
            a_gt_b = 1'b0;
        end else if (a[31] != b[31]) begin
            a_gt_b = ~a[31];
        end else if (!a[31]) begin
            a_gt_b = (a[30:0] > b[30:0]);
        end else begin
            a_gt_b = (a[30:0] < b[30:0]);
        end
    end
endmodule

// File: rtl/vect_argmax.sv
// Scans the fp32 y BRAM after the multiplier finishes and reports the index/value
// of the largest non-NaN element through a start/done/ack handshake.
module vect_argmax
    import vect_argmax_pkg::*;
#(
    parameter int unsigned addr_y_size = 12,
    parameter int unsigned length_M    = 512
) (
    input  logic         clk,
    input  logic         reset,
    vect_argmax_if.slave bus
);
    localparam int unsigned CNT_W = addr_y_size - 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(length_M - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [addr_y_size-1:0] addr_q, addr_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]       rd_idx_q, rd_idx_d;
    logic                   have_max_q, have_max_d;
    logic [31:0]            max_value_q, max_value_d;
    logic [CNT_W-1:0]       max_index_q, max_index_d;
    logic                   done_q, done_d;

    logic                   start;
    logic [31:0]            rd_data;
    logic                   rd_gt_max;
    logic                   unused_ctrl;

    assign start       = bus.ps_control[0];
    assign unused_ctrl = ^bus.ps_control[31:1];
    assign rd_data     = bus.bram_rddata_y;

    fp32_gt u_gt (
        .a      (rd_data),
        .b      (max_value_q),
        .a_gt_b (rd_gt_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            have_max_q  <= 1'b0;
            max_value_q <= '0;
            max_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_idx_q    <= rd_idx_d;
            have_max_q  <= have_max_d;
            max_value_q <= max_value_d;
            max_index_q <= max_index_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_valid_d  = 1'b0;
        rd_idx_d    = rd_idx_q;
        have_max_d  = have_max_q;
        max_value_d = max_value_q;
        max_index_d = max_index_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d     = SCAN;
                    have_max_d  = 1'b0;
                    max_value_d = '0;
                    max_index_d = '0;
                end
            end
            SCAN: begin
                rd_valid_d = 1'b1;
                rd_idx_d   = cnt_q;
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Data for the address issued last cycle is on the bus now; strict > keeps the lowest index on ties.
        if (rd_valid_q && !is_nan(rd_data) && (!have_max_q || rd_gt_max)) begin
            have_max_d  = 1'b1;
            max_value_d = rd_data;
            max_index_d = rd_idx_q;
        end

        addr_d = (state_d == SCAN) ? addr_y_size'(32'(cnt_d) * BYTES_PER_WORD) : '0;
        done_d = (state_d == DONE);
    end

    assign bus.pl_status     = {31'd0, done_q};
    assign bus.bram_addr_y   = addr_q;
    assign bus.bram_wrdata_y = 32'd0;
    assign bus.bram_we_y     = 4'h0;
    assign bus.max_index     = 16'(max_index_q);
    assign bus.max_value     = max_value_q;
    assign bus.max_valid     = have_max_q;
    assign bus.state         = 32'(state_q);

endmodule

// File: tb/tb_vect_argmax.sv
// Self-checking bench for vect_argmax: four instances (length 8, 512, 4, 1) share one y memory.
module tb_vect_argmax;

    localparam int LEN [4] = '{8, 512, 4, 1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        start [4];

    logic [31:0] o_status [4];
    logic [11:0] o_addr   [4];
    logic [15:0] o_idx    [4];
    logic [31:0] o_val    [4];
    logic        o_vld    [4];
    logic [31:0] o_state  [4];
    logic [31:0] o_wrdata [4];
    logic [3:0]  o_we     [4];

    int n_chk  = 0;
    int n_fail = 0;

    vect_argmax_if #(.ADDR_W(12)) if8 ();
    vect_argmax_if #(.ADDR_W(12)) if512 ();
    vect_argmax_if #(.ADDR_W(12)) if4 ();
    vect_argmax_if #(.ADDR_W(12)) if1 ();

    vect_argmax #(.addr_y_size(12), .length_M(8))   u_dut8   (.clk(clk), .reset(reset), .bus(if8));
    vect_argmax #(.addr_y_size(12), .length_M(512)) u_dut512 (.clk(clk), .reset(reset), .bus(if512));
    vect_argmax #(.addr_y_size(12), .length_M(4))   u_dut4   (.clk(clk), .reset(reset), .bus(if4));
    vect_argmax #(.addr_y_size(12), .length_M(1))   u_dut1   (.clk(clk), .reset(reset), .bus(if1));

    assign if8.ps_control   = {31'd0, start[0]};
    assign if512.ps_control = {31'd0, start[1]};
    assign if4.ps_control   = {31'd0, start[2]};
    assign if1.ps_control   = {31'd0, start[3]};

    // Synchronous-read BRAM models: data appears one cycle after the address.
    always @(posedge clk) begin
        if8.bram_rddata_y   <= mem[if8.bram_addr_y[11:2]];
        if512.bram_rddata_y <= mem[if512.bram_addr_y[11:2]];
        if4.bram_rddata_y   <= mem[if4.bram_addr_y[11:2]];
        if1.bram_rddata_y   <= mem[if1.bram_addr_y[11:2]];
    end

    assign o_status[0] = if8.pl_status;   assign o_status[1] = if512.pl_status;
    assign o_status[2] = if4.pl_status;   assign o_status[3] = if1.pl_status;
    assign o_addr[0]   = if8.bram_addr_y; assign o_addr[1]   = if512.bram_addr_y;
    assign o_addr[2]   = if4.bram_addr_y; assign o_addr[3]   = if1.bram_addr_y;
    assign o_idx[0]    = if8.max_index;   assign o_idx[1]    = if512.max_index;
    assign o_idx[2]    = if4.max_index;   assign o_idx[3]    = if1.max_index;
    assign o_val[0]    = if8.max_value;   assign o_val[1]    = if512.max_value;
    assign o_val[2]    = if4.max_value;   assign o_val[3]    = if1.max_value;
    assign o_vld[0]    = if8.max_valid;   assign o_vld[1]    = if512.max_valid;
    assign o_vld[2]    = if4.max_valid;   assign o_vld[3]    = if1.max_valid;
    assign o_state[0]  = if8.state;       assign o_state[1]  = if512.state;
    assign o_state[2]  = if4.state;       assign o_state[3]  = if1.state;
    assign o_wrdata[0] = if8.bram_wrdata_y; assign o_wrdata[1] = if512.bram_wrdata_y;
    assign o_wrdata[2] = if4.bram_wrdata_y; assign o_wrdata[3] = if1.bram_wrdata_y;
    assign o_we[0]     = if8.bram_we_y;   assign o_we[1]     = if512.bram_we_y;
    assign o_we[2]     = if4.bram_we_y;   assign o_we[3]     = if1.bram_we_y;

    logic [31:0] ga, gb;
    logic        g_out;
    fp32_gt u_gt (.a(ga), .b(gb), .a_gt_b(g_out));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference ordering: fp32 as a signed integer of its magnitude, so -0 and +0 both map to 0.
    function automatic longint fkey(input logic [31:0] f);
        longint m;
        m = longint'(f[30:0]);
        return f[31] ? -m : m;
    endfunction

    function automatic bit fnan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    endfunction

    function automatic void ref_argmax(input int n, output int idx, output logic [31:0] val,
                                       output bit vld);
        idx = 0; val = 32'd0; vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!fnan(mem[i]) && (!vld || fkey(mem[i]) > fkey(val))) begin
                idx = i; val = mem[i]; vld = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] int_to_fp(input int v);
        int e;
        if (v == 0) return 32'd0;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((v << (23 - e)) & 32'h007F_FFFF)};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 7))
            0: return {s, 8'hFF, 1'b1, 22'($urandom)};
            1: return {s, 31'd0};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 31'h3F80_0000 + 31'($urandom_range(0, 1) << 23)};
            default: return $urandom;
        endcase
    endfunction

    // Counts edges from the one that should move IDLE->SCAN until DONE; cyc = cycles from first SCAN.
    task automatic wait_done(input int sel, output int cyc);
        int  e = 0;
        int  addr_err = 0;
        bit  done = 1'b0;
        cyc = -1;
        while (!done && e < 2000) begin
            @(posedge clk); #1;
            e++;
            if (sel == 1 && o_state[sel] == 32'd1 && o_addr[sel] !== 12'(4 * (e - 1))) addr_err++;
            if (o_state[sel] == 32'd3) begin
                done = 1'b1;
                cyc = e - 1;
            end
        end
        check("done_reached", 32'(done), 32'd1);
        if (sel == 1) check("addr_walk_errors", addr_err, 32'd0);
    endtask

    task automatic run_scan(input int sel, output int cyc);
        @(negedge clk);
        start[sel] = 1'b1;
        wait_done(sel, cyc);
    endtask

    task automatic check_result(input string nm, input int sel, input int cyc, input int e_idx,
                                input logic [31:0] e_val, input bit e_vld);
        check({nm, "_latency"}, cyc, LEN[sel] + 1);
        check({nm, "_status"}, o_status[sel], 32'd1);
        check({nm, "_index"}, 32'(o_idx[sel]), e_idx);
        check({nm, "_value"}, o_val[sel], e_val);
        check({nm, "_valid"}, 32'(o_vld[sel]), 32'(e_vld));
    endtask

    // Hold start one more cycle (still DONE), then acknowledge and confirm results are held in IDLE.
    task automatic ack_scan(input string nm, input int sel, input int e_idx);
        @(posedge clk); #1;
        check({nm, "_done_hold"}, o_status[sel], 32'd1);
        @(negedge clk);
        start[sel] = 1'b0;
        @(posedge clk); #1;
        check({nm, "_idle_state"}, o_state[sel], 32'd0);
        check({nm, "_idle_status"}, o_status[sel], 32'd0);
        check({nm, "_held_index"}, 32'(o_idx[sel]), e_idx);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] y [8];
        int          e_idx;
        logic [31:0] e_val;
        bit          e_vld;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          cyc;
        int          r_idx;
        logic [31:0] r_val;
        bit          r_vld;

        for (int i = 0; i < 4; i++) start[i] = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        ga = 32'd0; gb = 32'd0;

        tbl[0] = '{0, '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000,
                        32'h40000000, 32'hC0000000, 32'h00000000, 32'h3FC00000}, 1, 32'h40000000, 1'b1};
        tbl[1] = '{2, '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hFF800000, 0, 0, 0, 0},
                   1, 32'hBF800000, 1'b1};
        tbl[2] = '{2, '{32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7FC00000, 0, 0, 0, 0},
                   1, 32'h80000000, 1'b1};
        tbl[3] = '{2, '{32'h7FC00000, 32'h7F800001, 32'hFFC00000, 32'hFFFFFFFF, 0, 0, 0, 0},
                   0, 32'h00000000, 1'b0};
        tbl[4] = '{3, '{32'hC2C80000, 0, 0, 0, 0, 0, 0, 0}, 0, 32'hC2C80000, 1'b1};
        tbl[5] = '{3, '{32'h7FC00000, 0, 0, 0, 0, 0, 0, 0}, 0, 32'h00000000, 1'b0};
        tbl[6] = '{2, '{32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'h7F800000, 0, 0, 0, 0},
                   0, 32'h7F800000, 1'b1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            check("rst_state", o_state[s], 32'd0);
            check("rst_status", o_status[s], 32'd0);
            check("rst_addr", 32'(o_addr[s]), 32'd0);
            check("rst_index", 32'(o_idx[s]), 32'd0);
            check("rst_value", o_val[s], 32'd0);
            check("rst_valid", 32'(o_vld[s]), 32'd0);
            check("wrdata_zero", o_wrdata[s], 32'd0);
            check("we_zero", 32'(o_we[s]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Comparator in isolation, against the integer-key reference.
        for (int i = 0; i < 40; i++) begin
            do ga = rnd_fp(); while (fnan(ga));
            do gb = (i % 3 == 0) ? {~ga[31], ga[30:0]} : rnd_fp(); while (fnan(gb));
            #1;
            check("fp32_gt_rand", 32'(g_out), 32'(fkey(ga) > fkey(gb)));
        end
        ga = 32'h80000000; gb = 32'h00000000; #1;
        check("fp32_gt_neg0_pos0", 32'(g_out), 32'd0);
        ga = 32'h00000000; gb = 32'h80000000; #1;
        check("fp32_gt_pos0_neg0", 32'(g_out), 32'd0);
        ga = 32'h7F800000; gb = 32'h7F7FFFFF; #1;
        check("fp32_gt_inf", 32'(g_out), 32'd1);

        // Directed table.
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 8; i++) mem[i] = tbl[t].y[i];
            run_scan(tbl[t].sel, cyc);
            check_result($sformatf("tbl%0d", t), tbl[t].sel, cyc, tbl[t].e_idx, tbl[t].e_val,
                         tbl[t].e_vld);
            ack_scan($sformatf("tbl%0d", t), tbl[t].sel, tbl[t].e_idx);
        end

        // Ramp of 512 integers: max at the last element, address walk checked on the way.
        for (int i = 0; i < 512; i++) mem[i] = int_to_fp(i);
        run_scan(1, cyc);
        check_result("ramp512", 1, cyc, 511, 32'h43FF8000, 1'b1);
        ack_scan("ramp512", 1, 511);

        // Randomized vectors against the reference model.
        for (int t = 0; t < 20; t++) begin
            int sel;
            sel = (t == 19) ? 1 : ((t % 2 == 0) ? 0 : 2);
            for (int i = 0; i < LEN[sel]; i++) mem[i] = rnd_fp();
            ref_argmax(LEN[sel], r_idx, r_val, r_vld);
            run_scan(sel, cyc);
            check_result($sformatf("rand%0d", t), sel, cyc, r_idx, r_val, r_vld);
            ack_scan($sformatf("rand%0d", t), sel, r_idx);
        end

        // Reset in the middle of a scan (counter at 3), then restart with start still held.
        for (int i = 0; i < 8; i++) mem[i] = tbl[0].y[i];
        @(negedge clk);
        start[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midscan_state", o_state[0], 32'd1);
        check("midscan_addr", 32'(o_addr[0]), 32'd12);
        reset = 1'b1;
        #1;
        check("midrst_state", o_state[0], 32'd0);
        check("midrst_status", o_status[0], 32'd0);
        check("midrst_addr", 32'(o_addr[0]), 32'd0);
        check("midrst_index", 32'(o_idx[0]), 32'd0);
        check("midrst_value", o_val[0], 32'd0);
        check("midrst_valid", 32'(o_vld[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_done(0, cyc);
        check_result("restart", 0, cyc, 1, 32'h40000000, 1'b1);
        ack_scan("restart", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
